// File: rtl/intt_pkg.sv
// Shared constants and types for the inverse NTT block.
// Widths here must agree with the intt parameters used at instantiation.
package intt_pkg;

  localparam int          N      = 64;
  localparam logic [63:0] Q      = 64'hFFFFFFFF00000001;
  localparam logic [63:0] NINV   = 64'hFBFFFFFF04000001;
  localparam int          DATA_W = 64;
  localparam int          W_W    = 8;
  localparam int          IDX_W  = $clog2(N);
  localparam int          CNT_W  = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/intt_if.sv
// Input/output streaming handshake bundle for the inverse NTT block.
// The master side drives the input beats and consumes the output words.
interface intt_if #(
  parameter int N = 64
);
  import intt_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [N-1:0][W_W-1:0]      in_w;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [$clog2(N)-1:0]       out_idx;
  logic                       busy;

  modport master (
    output in_valid, in_data, in_w, out_ready,
    input  in_ready, out_valid, out_data, out_idx, busy
  );

  modport slave (
    input  in_valid, in_data, in_w, out_ready,
    output in_ready, out_valid, out_data, out_idx, busy
  );

endinterface

// File: rtl/intt_modmul.sv
// Combinational (a*b + c) mod Q. The full-width sum is kept before reduction,
// so operands need not be pre-reduced.
module intt_modmul
  import intt_pkg::*;
#(
  parameter int          AW = 64,
  parameter int          BW = 64,
  parameter logic [63:0] QM = intt_pkg::Q
) (
  input  logic [AW-1:0]     a_i,
  input  logic [BW-1:0]     b_i,
  input  logic [DATA_W-1:0] c_i,
  output logic [DATA_W-1:0] r_o
);

  localparam int FW = AW + BW + 1;

  logic [FW-1:0] full;

  assign full = FW'(a_i) * FW'(b_i) + FW'(c_i);
  assign r_o  = DATA_W'(full % FW'(QM));

endmodule

// File: rtl/intt.sv
// Inverse NTT: accumulates N spectral beats into N MAC lanes, then streams
// the N scaled time-domain samples out in index order.
//   state    | meaning
//   ST_IDLE  | waiting for first beat; a beat overwrites the accumulators
//   ST_ACCUM | accumulating beats 1..N-1
//   ST_DRAIN | input blocked; scaling and emitting acc[0..N-1]
module intt #(
  parameter int          N    = intt_pkg::N,
  parameter logic [63:0] Q    = intt_pkg::Q,
  parameter logic [63:0] NINV = intt_pkg::NINV
) (
  input logic   clk,
  input logic   rst,
  intt_if.slave bus
);
  import intt_pkg::*;

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] acc_q [N];
  logic [DATA_W-1:0] mac_r [N];
  logic              acc_load;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IW-1:0]     out_idx_q, out_idx_d;
  logic [IW-1:0]     sel_idx;
  logic [DATA_W-1:0] scale_r;

  for (genvar j = 0; j < N; j++) begin : g_lane
    intt_modmul #(.AW(W_W), .BW(DATA_W), .QM(Q)) u_mac (
      .a_i (bus.in_w[j]),
      .b_i (bus.in_data),
      .c_i ((state_q == ST_ACCUM) ? acc_q[j] : 64'd0),
      .r_o (mac_r[j])
    );
  end

  // The scaler looks one word ahead so a handshake can present idx+1 next cycle.
  assign sel_idx = out_valid_q ? (out_idx_q + IW'(1)) : '0;

  intt_modmul #(.AW(DATA_W), .BW(DATA_W), .QM(Q)) u_scale (
    .a_i (acc_q[sel_idx]),
    .b_i (NINV),
    .c_i (64'd0),
    .r_o (scale_r)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_load    = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          acc_load = 1'b1;
          count_d  = CW'(1);
          state_d  = (N == 1) ? ST_DRAIN : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.in_valid) begin
          acc_load = 1'b1;
          count_d  = count_q + CW'(1);
          if (count_q == CW'(N - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_idx_d   = '0;
          out_data_d  = scale_r;
        end else if (bus.out_ready) begin
          if (out_idx_q == IW'(N - 1)) begin
            out_valid_d = 1'b0;
            count_d     = '0;
            state_d     = ST_IDLE;
          end else begin
            out_idx_d  = out_idx_q + IW'(1);
            out_data_d = scale_r;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      for (int j = 0; j < N; j++) acc_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      for (int j = 0; j < N; j++) begin
        if (acc_load) acc_q[j] <= mac_r[j];
      end
    end
  end

  assign bus.in_ready  = (state_q != ST_DRAIN);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_intt.sv
// Self-checking bench for intt: fixed-pattern vector table, backpressure,
// gapped input, reset mid-frame and random frames against a direct-sum model.
module tb_intt;

  localparam int          NP     = 64;
  localparam logic [63:0] QM     = 64'hFFFFFFFF00000001;
  localparam logic [63:0] NINV_M = 64'hFBFFFFFF04000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  intt_if #(.N(NP)) bus();

  intt #(.N(NP)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] xs  [NP];
  logic [7:0]  ws  [NP][NP];
  logic [63:0] got [NP];

  typedef struct {
    logic [63:0] x0;
    logic [63:0] xr;
    logic [7:0]  w;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [7];

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // y[j] = NINV * sum_k w[k][j] * (x[k] mod Q), computed over the whole frame at once
  function automatic logic [63:0] model(input int j);
    logic [127:0] s;
    s = '0;
    for (int k = 0; k < NP; k++)
      s = (s + 128'(ws[k][j]) * (128'(xs[k]) % 128'(QM))) % 128'(QM);
    return 64'((s * 128'(NINV_M)) % 128'(QM));
  endfunction

  task automatic fill_uniform(input logic [63:0] x0, input logic [63:0] xr, input logic [7:0] w);
    for (int k = 0; k < NP; k++) begin
      xs[k] = (k == 0) ? x0 : xr;
      for (int j = 0; j < NP; j++) ws[k][j] = w;
    end
  endtask

  task automatic run_frame(input int gap_pct, input bit rnd_ready, input int bp_idx,
                           input int bp_len, input bit junk);
    int          k = 0;
    int          cyc = 0;
    int          nexp = 0;
    int          lat = -1;
    int          held = 0;
    int          stable_err = 0;
    int          ready_hi = 0;
    bit          irdy, ordy, ov;
    logic [63:0] hd, od;
    logic [5:0]  hi, oi;
    hd = '0;
    hi = '0;
    while (k < NP && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = xs[k];
        for (int j = 0; j < NP; j++) bus.in_w[j] = ws[k][j];
      end
      irdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && irdy) k++;
    end
    check64("in_beats", 64'(k), 64'(NP));
    cyc = 0;
    while (nexp < NP && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      bus.in_valid = junk;
      if (junk) bus.in_data = {$urandom, $urandom};
      if (bus.in_ready) ready_hi++;
      if (bus.out_valid && lat < 0) lat = cyc;
      if (bus.out_valid && int'(bus.out_idx) == bp_idx && held < bp_len) begin
        if (held == 0) begin
          hd = bus.out_data;
          hi = bus.out_idx;
        end else if (bus.out_data !== hd || bus.out_idx !== hi) begin
          stable_err++;
        end
        held++;
        bus.out_ready = 1'b0;
      end else begin
        bus.out_ready = rnd_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
      ordy = bus.out_ready;
      ov   = bus.out_valid;
      od   = bus.out_data;
      oi   = bus.out_idx;
      @(posedge clk);
      if (ov && ordy) begin
        check64("out_idx_order", 64'(oi), 64'(nexp));
        got[nexp] = od;
        nexp++;
      end
    end
    check64("out_words", 64'(nexp), 64'(NP));
    check64("first_out_latency", 64'(lat), 64'd2);
    check64("in_ready_in_drain", 64'(ready_hi), 64'd0);
    if (bp_len > 0) begin
      check64("bp_hold_cycles", 64'(held), 64'(bp_len));
      check64("bp_stable", 64'(stable_err), 64'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check64("end_out_valid", 64'(bus.out_valid), 64'd0);
    check64("end_busy", 64'(bus.busy), 64'd0);
    check64("end_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic check_const(input string name, input logic [63:0] exp);
    for (int j = 0; j < NP; j++) check64(name, got[j], exp);
  endtask

  initial begin
    vt[0] = '{x0: 64'd1,                 xr: 64'd0,                 w: 8'd1,   exp: NINV_M};
    vt[1] = '{x0: 64'd64,                xr: 64'd64,                w: 8'd1,   exp: 64'd64};
    vt[2] = '{x0: QM - 64'd1,            xr: QM - 64'd1,            w: 8'd255, exp: 64'hFFFFFFFEFFFFFF02};
    vt[3] = '{x0: QM,                    xr: QM,                    w: 8'd7,   exp: 64'd0};
    vt[4] = '{x0: QM + 64'd5,            xr: QM + 64'd5,            w: 8'd3,   exp: 64'd15};
    vt[5] = '{x0: 64'hFFFFFFFFFFFFFFFF,  xr: 64'hFFFFFFFFFFFFFFFF,  w: 8'd1,   exp: 64'h00000000FFFFFFFE};
    vt[6] = '{x0: 64'd9,                 xr: 64'd9,                 w: 8'd0,   exp: 64'd0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_w      = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check64("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check64("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check64("rst_busy", 64'(bus.busy), 64'd0);
    check64("rst_out_data", bus.out_data, 64'd0);
    check64("rst_out_idx", 64'(bus.out_idx), 64'd0);

    for (int v = 0; v < 7; v++) begin
      fill_uniform(vt[v].x0, vt[v].xr, vt[v].w);
      run_frame(0, 1'b0, -1, 0, 1'b0);
      check_const($sformatf("vec%0d", v), vt[v].exp);
    end

    fill_uniform(64'd64, 64'd64, 8'd1);
    run_frame(0, 1'b0, 10, 5, 1'b0);
    check_const("backpressure", 64'd64);

    run_frame(30, 1'b0, -1, 0, 1'b1);
    check_const("gapped", 64'd64);

    // abort a frame after 30 beats with a beat offered on the reset edge
    fill_uniform(64'd64, 64'd64, 8'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = xs[k];
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check64("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check64("abort_busy", 64'(bus.busy), 64'd0);
    check64("abort_in_ready", 64'(bus.in_ready), 64'd1);
    begin
      int seen = 0;
      bus.out_ready = 1'b1;
      repeat (80) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      bus.out_ready = 1'b0;
      check64("abort_no_words", 64'(seen), 64'd0);
    end
    fill_uniform(64'd1, 64'd0, 8'd1);
    run_frame(0, 1'b0, -1, 0, 1'b0);
    check_const("after_abort", NINV_M);

    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NP; k++) begin
        xs[k] = {$urandom, $urandom};
        if ($urandom_range(7) == 0) xs[k] = QM + 64'($urandom_range(1000));
        for (int j = 0; j < NP; j++) ws[k][j] = 8'($urandom_range(255));
      end
      run_frame(25, 1'b1, int'($urandom_range(NP - 1)), 3, 1'b1);
      for (int j = 0; j < NP; j++) check64($sformatf("rand%0d_y%0d", f, j), got[j], model(j));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
